program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Host-side loader sitting directly upstream of the CPU's RAM programming port.
- Accepts a byte stream over a valid/ready handshake and writes it into consecutive RAM addresses via the input_mode / input_address / input_program interface.
- Holds the CPU in reset while loading, then releases it so execution starts at address 0h.

Parameters:
- ADDR_W, 4, RAM address width (16 locations).
- DATA_W, 8, instruction/data byte width.
- RST_CYCLES, 2, number of cycles cpu_reset is held low after the last write (≥1).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- load_start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- load_base  in  ADDR_W  first RAM address, sampled with load_start.
- load_len  in  ADDR_W+1  byte count, sampled with load_start.
- host_valid  in  1  host byte valid.
- host_data  in  DATA_W  host byte.
- host_ready  out  1  loader can accept a byte this cycle.
- abort  in  1  cancels an in-progress load.
- input_mode  out  1  RAM write strobe; high exactly one cycle per written byte.
- input_address  out  ADDR_W  RAM write address.
- input_program  out  DATA_W  RAM write data.
- cpu_reset  out  1  active-low reset to the CPU blocks.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on successful completion.
- aborted  out  1  one-cycle pulse when an abort is taken.
- bytes_written  out  ADDR_W+1  count of bytes written in the current or last load.

Behaviour:
- Reset (reset=0 at a clock edge):
  - state → IDLE.
  - input_mode=0, input_address=0, input_program=0, host_ready=0, busy=0, done=0, aborted=0, bytes_written=0.
  - cpu_reset=0 while reset is held; first IDLE cycle after reset drives cpu_reset=1.
- States:
  - IDLE: cpu_reset=1, host_ready=0. load_start=1 latches base, saturated length (len>16 → 16) and clears bytes_written.
    - If saturated len=0 → RST. Otherwise → LOAD.
  - LOAD: cpu_reset=0, host_ready=1.
    - A beat transfers when host_valid & host_ready at an edge.
    - At that edge input_address ← (base + bytes_written) mod 16, input_program ← host_data, input_mode ← 1, bytes_written increments.
    - With no transfer, input_mode ← 0 next cycle. Maximum throughput is 1 byte/cycle.
    - When the final beat transfers → WFIN.
  - WFIN: one cycle. input_mode is high for the last byte; host_ready=0; cpu_reset=0 → RST.
  - RST: input_mode=0, cpu_reset=0 for RST_CYCLES cycles (counter) → DONE.
  - DONE: one cycle. done=1, cpu_reset=1, busy=1 → IDLE.
- Address and data:
  - Address wraps 15→0. Base Eh with len 3 writes Eh, Fh, 0h.
  - input_address and input_program hold their last values when input_mode=0.
- Abort:
  - abort=1 in LOAD or WFIN wins over a simultaneous beat; that beat is not written.
  - Next cycle: input_mode=0, aborted=1, state=IDLE, cpu_reset=1. bytes_written keeps the partial count. No RST sequence.
  - abort is ignored in IDLE, RST and DONE.
- load_start outside IDLE is ignored.
- host_valid is ignored outside LOAD; host_ready is 0 there.
- Reset mid-load: immediate return to reset values. Bytes already strobed remain in RAM.

Decomposition:
- Shared package (cpu_pkg): loader state enum (IDLE, LOAD, WFIN, RST, DONE), ADDR_W and DATA_W constants, RAM depth constant 16.
- Single module; no sub-module needed. The RST_CYCLES down-counter stays inline.

Test Plan:
- Basic load: base 0h, len 4, bytes 79h, 30h, 7Ah, 20h, back-to-back → four single-cycle input_mode pulses at addresses 0, 1, 2, 3 with matching data; cpu_reset low 2 cycles after the last strobe; done pulse; bytes_written=4. Full CPU then computes 8−1=7 in A.
- Backpressure gaps: same stream with host_valid low 1–3 cycles between bytes → no extra input_mode pulses, identical address/data sequence.
- Wrap: base Eh, len 3, data 11h, 22h, 33h → writes Eh=11h, Fh=22h, 0h=33h.
- Length edges: len 0 → no input_mode pulse, RST for 2 cycles, done. len 20 → exactly 16 writes, bytes_written=16.
- Abort: len 4, abort asserted with the 3rd beat → 2 writes only, aborted pulse, no done, cpu_reset=1, bytes_written=2. A load_start during LOAD is ignored.
- Reset mid-load: reset=0 after 1 byte → all outputs at reset values next edge. A new load from base 0h then succeeds.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-side constants and the program loader state type.
// Provides ADDR_W, DATA_W, RAM_DEPTH and ld_state_e.
package cpu_pkg;

    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 8;
    localparam int RAM_DEPTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WFIN,
        RST,
        DONE
    } ld_state_e;

endpackage

// File: rtl/program_loader.sv
// Host byte-stream loader feeding the CPU RAM programming port.
// Ports: clk, reset (sync, active-low); load_start/load_base/load_len
//   start a load; host_valid/host_data/host_ready carry bytes; abort
//   cancels; input_mode/input_address/input_program write RAM;
//   cpu_reset holds the CPU; busy/done/aborted/bytes_written report.
module program_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = cpu_pkg::ADDR_W,
    parameter int DATA_W     = cpu_pkg::DATA_W,
    parameter int RST_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W:0]   load_len,
    input  logic              host_valid,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_ready,
    input  logic              abort,
    output logic              input_mode,
    output logic [ADDR_W-1:0] input_address,
    output logic [DATA_W-1:0] input_program,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [ADDR_W:0]   bytes_written
);

    localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [ADDR_W:0]  LEN_MAX  = (ADDR_W+1)'(1 << ADDR_W);
    localparam logic [ADDR_W:0]  ONE      = (ADDR_W+1)'(1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    ld_state_e         state;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   len;
    logic [CNT_W-1:0]  cnt;

    logic [ADDR_W:0]   len_sat;
    logic [ADDR_W:0]   bw_next;
    logic              beat;

    // Lengths beyond the RAM size would only overwrite the same words.
    assign len_sat = (load_len > LEN_MAX) ? LEN_MAX : load_len;
    assign bw_next = bytes_written + ONE;
    assign beat    = host_valid & host_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            base          <= '0;
            len           <= '0;
            cnt           <= '0;
            host_ready    <= 1'b0;
            input_mode    <= 1'b0;
            input_address <= '0;
            input_program <= '0;
            cpu_reset     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            bytes_written <= '0;
        end else begin
            done       <= 1'b0;
            aborted    <= 1'b0;
            input_mode <= 1'b0;

            unique case (state)
                IDLE: begin
                    cpu_reset <= 1'b1;
                    if (load_start) begin
                        base          <= load_base;
                        len           <= len_sat;
                        bytes_written <= '0;
                        busy          <= 1'b1;
                        cpu_reset     <= 1'b0;
                        if (len_sat == '0) begin
                            state <= RST;
                            cnt   <= CNT_INIT;
                        end else begin
                            state      <= LOAD;
                            host_ready <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    // Abort wins over a beat offered in the same cycle.
                    if (abort) begin
                        state      <= IDLE;
                        host_ready <= 1'b0;
                        busy       <= 1'b0;
                        cpu_reset  <= 1'b1;
                        aborted    <= 1'b1;
                    end else if (beat) begin
                        input_mode    <= 1'b1;
                        input_address <= base + bytes_written[ADDR_W-1:0];
                        input_program <= host_data;
                        bytes_written <= bw_next;
                        if (bw_next == len) begin
                            state      <= WFIN;
                            host_ready <= 1'b0;
                        end
                    end
                end

                WFIN: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cpu_reset <= 1'b1;
                        aborted   <= 1'b1;
                    end else begin
                        state <= RST;
                        cnt   <= CNT_INIT;
                    end
                end

                RST: begin
                    if (cnt == '0) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        cpu_reset <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader.
// Directed and random loads checked against a RAM-image reference model.
module tb_program_loader;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int RC = 2;

    typedef int bytes_t [16];

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic          clk        = 1'b0;
    logic          reset      = 1'b0;
    logic          load_start = 1'b0;
    logic [AW-1:0] load_base  = '0;
    logic [AW:0]   load_len   = '0;
    logic          host_valid = 1'b0;
    logic [DW-1:0] host_data  = '0;
    logic          abort      = 1'b0;
    logic          host_ready;
    logic          input_mode;
    logic [AW-1:0] input_address;
    logic [DW-1:0] input_program;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [AW:0]   bytes_written;

    program_loader #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .RST_CYCLES(RC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .load_start(load_start),
        .load_base(load_base),
        .load_len(load_len),
        .host_valid(host_valid),
        .host_data(host_data),
        .host_ready(host_ready),
        .abort(abort),
        .input_mode(input_mode),
        .input_address(input_address),
        .input_program(input_program),
        .cpu_reset(cpu_reset),
        .busy(busy),
        .done(done),
        .aborted(aborted),
        .bytes_written(bytes_written)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: the RAM as the CPU would see it, plus pulse counters.
    wr_t wq[$];
    int  ram     [16] = '{default: 0};
    int  exp_ram [16] = '{default: 0};
    int  done_cnt    = 0;
    int  abort_cnt   = 0;
    int  low_run     = 0;
    int  low_at_done = -1;

    always @(posedge clk) begin
        #1;
        if (input_mode) begin
            wq.push_back('{int'(input_address), int'(input_program)});
            ram[input_address] = int'(input_program);
        end
        if (!busy || input_mode) low_run = 0;
        else if (!cpu_reset) low_run++;
        if (done) begin
            done_cnt++;
            low_at_done = low_run;
        end
        if (aborted) abort_cnt++;
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_mode"}, 32'(input_mode), 0);
        check({tag, "_addr"}, 32'(input_address), 0);
        check({tag, "_prog"}, 32'(input_program), 0);
        check({tag, "_ready"}, 32'(host_ready), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_aborted"}, 32'(aborted), 0);
        check({tag, "_count"}, 32'(bytes_written), 0);
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 0);
    endtask

    task automatic run_load(input int base, input int len, input bytes_t din,
                            input bit gaps, input int abort_at,
                            input bit stray);
        int n, nw, i, cyc, gap, q0, d0, a0, bad;
        bit stop;
        n  = (len > 16) ? 16 : len;
        nw = (abort_at >= 0) ? abort_at : n;
        q0 = wq.size();
        d0 = done_cnt;
        a0 = abort_cnt;

        load_base  = AW'(base);
        load_len   = (AW+1)'(len);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        check("start_busy", 32'(busy), 1);
        check("start_ready", 32'(host_ready), (n > 0) ? 1 : 0);
        check("start_cpu_reset", 32'(cpu_reset), 0);
        check("start_count", 32'(bytes_written), 0);

        i    = 0;
        cyc  = 0;
        stop = 1'b0;
        gap  = gaps ? int'($urandom_range(3, 1)) : 0;
        while (i < n && !stop && cyc < 300) begin
            if (gap > 0) begin
                host_valid = 1'b0;
                host_data  = DW'($urandom);
                gap--;
            end else begin
                host_valid = 1'b1;
                host_data  = DW'(din[i]);
                if (stray && i == 1) begin
                    load_start = 1'b1;
                    load_base  = AW'(base + 7);
                    load_len   = 1;
                end
                if (i == abort_at) begin
                    abort = 1'b1;
                    stop  = 1'b1;
                end else if (host_ready) begin
                    i++;
                    gap = gaps ? int'($urandom_range(3, 1)) : 0;
                end
            end
            @(negedge clk);
            cyc++;
            load_start = 1'b0;
            abort      = 1'b0;
            host_valid = 1'b0;
        end
        if (!stop) check("fed_all", i, n);

        if (abort_at >= 0) begin
            check("abort_pulse", 32'(aborted), 1);
            check("abort_mode", 32'(input_mode), 0);
            check("abort_cpu_reset", 32'(cpu_reset), 1);
            check("abort_busy", 32'(busy), 0);
            check("abort_count", 32'(bytes_written), nw);
            repeat (4) @(negedge clk);
            check("abort_one_pulse", abort_cnt - a0, 1);
            check("abort_no_done", done_cnt - d0, 0);
        end else begin
            cyc = 0;
            while (done_cnt == d0 && cyc < 40) begin
                @(negedge clk);
                cyc++;
            end
            check("done_pulse", 32'(done), 1);
            check("done_busy", 32'(busy), 1);
            check("done_cpu_reset", 32'(cpu_reset), 1);
            check("done_count", 32'(bytes_written), n);
            check("rst_low_cycles", low_at_done, RC);
            @(negedge clk);
            check("after_done", 32'(done), 0);
            check("after_busy", 32'(busy), 0);
            check("after_cpu_reset", 32'(cpu_reset), 1);
            check("one_done", done_cnt - d0, 1);
        end

        check("n_writes", wq.size() - q0, nw);
        for (int k = 0; k < nw && q0 + k < wq.size(); k++) begin
            check("wr_addr", wq[q0+k].addr, (base + k) % 16);
            check("wr_data", wq[q0+k].data, din[k]);
        end
        for (int k = 0; k < nw; k++) exp_ram[(base + k) % 16] = din[k];
        bad = 0;
        for (int k = 0; k < 16; k++) if (ram[k] != exp_ram[k]) bad++;
        check("ram_image", bad, 0);
    endtask

    initial begin
        bytes_t d;

        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b1;
        @(negedge clk);
        check("por_cpu_reset_rel", 32'(cpu_reset), 1);
        check("por_busy_rel", 32'(busy), 0);

        d = '{default: 0};
        d[0] = 'h79; d[1] = 'h30; d[2] = 'h7a; d[3] = 'h20;
        run_load(0, 4, d, 1'b0, -1, 1'b0);
        run_load(0, 4, d, 1'b1, -1, 1'b0);

        d[0] = 'h11; d[1] = 'h22; d[2] = 'h33;
        run_load(14, 3, d, 1'b0, -1, 1'b0);

        run_load(3, 0, d, 1'b0, -1, 1'b0);

        for (int k = 0; k < 16; k++) d[k] = int'($urandom_range(255));
        run_load(5, 20, d, 1'b1, -1, 1'b0);

        for (int k = 0; k < 16; k++) d[k] = int'($urandom_range(255));
        run_load(6, 4, d, 1'b0, 2, 1'b1);

        repeat (6) begin
            for (int k = 0; k < 16; k++) d[k] = int'($urandom_range(255));
            run_load(int'($urandom_range(15)), int'($urandom_range(20)), d,
                     1'($urandom_range(1)), -1, 1'b0);
        end

        d[0] = int'($urandom_range(255));
        load_base  = 5;
        load_len   = 8;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        host_valid = 1'b1;
        host_data  = DW'(d[0]);
        @(negedge clk);
        host_valid = 1'b0;
        exp_ram[5] = d[0];
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("midrst");
        reset = 1'b1;
        @(negedge clk);
        check("midrst_cpu_reset_rel", 32'(cpu_reset), 1);

        for (int k = 0; k < 16; k++) d[k] = int'($urandom_range(255));
        run_load(0, 4, d, 1'b0, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
